// File: rtl/cp0_exc_sequencer_pkg.sv
// Shared definitions for the CP0 exception/interrupt sequencer: state encoding,
// ExcCode values, CP0 register numbers and the debug counter increment helper.
package cp0_exc_sequencer_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_DRAIN = 1'b1
    } state_e;

    localparam logic [4:0] EXC_INT  = 5'd0;
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;
    localparam logic [4:0] EXC_RI   = 5'd10;
    localparam logic [4:0] EXC_OV   = 5'd12;

    localparam logic [4:0] CP0_REG_SR    = 5'd12;
    localparam logic [4:0] CP0_REG_CAUSE = 5'd13;
    localparam logic [4:0] CP0_REG_EPC   = 5'd14;
    localparam logic [4:0] CP0_REG_PRID  = 5'd15;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/cp0_exc_sequencer_if.sv
// M-stage event inputs, CP0 feedback and CP0/fetch control strobes of the
// exception sequencer; the pipeline side is master, the sequencer is slave.
interface cp0_exc_sequencer_if;
    logic        m_valid;
    logic [31:0] m_pc;
    logic        m_bd;
    logic        m_exc_valid;
    logic [4:0]  m_exc_code;
    logic        m_is_eret;
    logic        int_req;
    logic [31:0] cp0_epc;
    logic        exl_set;
    logic        exl_clr;
    logic [4:0]  exc_code;
    logic        exc_bd;
    logic [31:0] exc_pc;
    logic        flush;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        busy;
    logic [15:0] taken_cnt;

    modport master (
        output m_valid, m_pc, m_bd, m_exc_valid, m_exc_code, m_is_eret, int_req, cp0_epc,
        input  exl_set, exl_clr, exc_code, exc_bd, exc_pc, flush, redirect, redirect_pc,
               busy, taken_cnt
    );

    modport slave (
        input  m_valid, m_pc, m_bd, m_exc_valid, m_exc_code, m_is_eret, int_req, cp0_epc,
        output exl_set, exl_clr, exc_code, exc_bd, exc_pc, flush, redirect, redirect_pc,
               busy, taken_cnt
    );
endinterface

// File: rtl/cp0_exc_sequencer.sv
// CP0 exception/interrupt sequencer: zero-latency arbitration at the M-stage commit
// point, CP0 strobes and PC redirect, then a fixed drain window ignoring new events.
module cp0_exc_sequencer
    import cp0_exc_sequencer_pkg::*;
#(
    parameter logic [31:0] HANDLER_PC   = 32'h0000_4180,
    parameter int          DRAIN_CYCLES = 2,
    parameter int          CNT_W        = 2
) (
    input logic                clk,
    input logic                reset,
    cp0_exc_sequencer_if.slave bus
);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [15:0]      taken_cnt_q, taken_cnt_d;

    logic        exl_set_c;
    logic        exl_clr_c;
    logic [4:0]  exc_code_c;
    logic        exc_bd_c;
    logic [31:0] exc_pc_c;
    logic [31:0] redirect_pc_c;

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        taken_cnt_d   = taken_cnt_q;
        exl_set_c     = 1'b0;
        exl_clr_c     = 1'b0;
        exc_code_c    = 5'd0;
        exc_bd_c      = 1'b0;
        exc_pc_c      = 32'd0;
        redirect_pc_c = 32'd0;
        case (state_q)
            ST_IDLE: begin
                // Interrupt outranks a synchronous exception and ERET; the loser re-occurs later.
                if (bus.m_valid && (bus.int_req || bus.m_exc_valid)) begin
                    exl_set_c     = 1'b1;
                    exc_code_c    = bus.int_req ? EXC_INT : bus.m_exc_code;
                    exc_bd_c      = bus.m_bd;
                    exc_pc_c      = bus.m_pc;
                    redirect_pc_c = HANDLER_PC;
                    taken_cnt_d   = sat_inc16(taken_cnt_q);
                    state_d       = ST_DRAIN;
                    cnt_d         = CNT_W'(DRAIN_CYCLES - 1);
                end else if (bus.m_valid && bus.m_is_eret) begin
                    exl_clr_c     = 1'b1;
                    redirect_pc_c = bus.cp0_epc;
                    state_d       = ST_DRAIN;
                    cnt_d         = CNT_W'(DRAIN_CYCLES - 1);
                end
            end
            ST_DRAIN: begin
                if (cnt_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            taken_cnt_q <= 16'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            taken_cnt_q <= taken_cnt_d;
        end
    end

    // Strobes are Mealy on the M-stage inputs, so reset must mask them directly.
    assign bus.exl_set     = exl_set_c & ~reset;
    assign bus.exl_clr     = exl_clr_c & ~reset;
    assign bus.flush       = (exl_set_c | exl_clr_c) & ~reset;
    assign bus.redirect    = (exl_set_c | exl_clr_c) & ~reset;
    assign bus.exc_code    = reset ? 5'd0  : exc_code_c;
    assign bus.exc_bd      = exc_bd_c & ~reset;
    assign bus.exc_pc      = reset ? 32'd0 : exc_pc_c;
    assign bus.redirect_pc = reset ? 32'd0 : redirect_pc_c;
    assign bus.busy        = (state_q != ST_IDLE);
    assign bus.taken_cnt   = taken_cnt_q;

endmodule

// File: tb/tb_cp0_exc_sequencer.sv
// Directed bench for cp0_exc_sequencer: a behavioural model pushes expected outputs
// to a scoreboard queue each cycle, popped and checked just before the clock edge.
module tb_cp0_exc_sequencer;

    localparam logic [31:0] HPC = 32'h0000_4180;

    logic clk;
    logic reset;
    cp0_exc_sequencer_if bus ();

    cp0_exc_sequencer #(
        .HANDLER_PC  (HPC),
        .DRAIN_CYCLES(2),
        .CNT_W       (2)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        exl_set;
        logic        exl_clr;
        logic [4:0]  exc_code;
        logic        exc_bd;
        logic [31:0] exc_pc;
        logic        flush;
        logic        redirect;
        logic [31:0] redirect_pc;
        logic        busy;
        logic [15:0] taken_cnt;
    } exp_t;

    exp_t        sb_q[$];
    int          total = 0;
    int          bad   = 0;
    logic        mdl_busy;
    int          mdl_cnt;
    logic [15:0] mdl_taken;

    task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag, input exp_t e);
        cmp({tag, ".exl_set"},     32'(bus.exl_set),     32'(e.exl_set));
        cmp({tag, ".exl_clr"},     32'(bus.exl_clr),     32'(e.exl_clr));
        cmp({tag, ".exc_code"},    32'(bus.exc_code),    32'(e.exc_code));
        cmp({tag, ".exc_bd"},      32'(bus.exc_bd),      32'(e.exc_bd));
        cmp({tag, ".exc_pc"},      bus.exc_pc,           e.exc_pc);
        cmp({tag, ".flush"},       32'(bus.flush),       32'(e.flush));
        cmp({tag, ".redirect"},    32'(bus.redirect),    32'(e.redirect));
        cmp({tag, ".redirect_pc"}, bus.redirect_pc,      e.redirect_pc);
        cmp({tag, ".busy"},        32'(bus.busy),        32'(e.busy));
        cmp({tag, ".taken_cnt"},   32'(bus.taken_cnt),   32'(e.taken_cnt));
    endtask

    function automatic exp_t zero_exp();
        exp_t e;
        e = '0;
        return e;
    endfunction

    task automatic model_reset();
        mdl_busy  = 1'b0;
        mdl_cnt   = 0;
        mdl_taken = 16'd0;
    endtask

    // One cycle starting at a negedge: drive, predict, push, sample before posedge.
    task automatic step(input string tag, input logic v, input logic [31:0] pc, input logic bd,
                        input logic ev, input logic [4:0] code, input logic eret,
                        input logic ir, input logic [31:0] epc);
        exp_t e;
        exp_t got;
        bus.m_valid     = v;
        bus.m_pc        = pc;
        bus.m_bd        = bd;
        bus.m_exc_valid = ev;
        bus.m_exc_code  = code;
        bus.m_is_eret   = eret;
        bus.int_req     = ir;
        bus.cp0_epc     = epc;
        e = '0;
        e.busy      = mdl_busy;
        e.taken_cnt = mdl_taken;
        if (!mdl_busy) begin
            if (v && (ir || ev)) begin
                e.exl_set     = 1'b1;
                e.flush       = 1'b1;
                e.redirect    = 1'b1;
                e.exc_code    = ir ? 5'd0 : code;
                e.exc_bd      = bd;
                e.exc_pc      = pc;
                e.redirect_pc = HPC;
            end else if (v && eret) begin
                e.exl_clr     = 1'b1;
                e.flush       = 1'b1;
                e.redirect    = 1'b1;
                e.redirect_pc = epc;
            end
        end
        sb_q.push_back(e);
        #2;
        total++;
        assert (sb_q.size() > 0) else begin
            bad++;
            $error("FAIL %s.sb_empty: got 0 want 1", tag);
        end
        if (sb_q.size() > 0) begin
            got = sb_q.pop_front();
            check_all(tag, got);
        end
        if (mdl_busy) begin
            if (mdl_cnt == 0) mdl_busy = 1'b0;
            else mdl_cnt = mdl_cnt - 1;
        end else if (e.exl_set || e.exl_clr) begin
            mdl_busy = 1'b1;
            mdl_cnt  = 1;
            if (e.exl_set && mdl_taken != 16'hFFFF) mdl_taken = mdl_taken + 16'd1;
        end
        @(negedge clk);
    endtask

    task automatic idle(input string tag);
        step(tag, 1'b0, 32'h0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 32'h0);
    endtask

    initial begin
        exp_t z;
        z = zero_exp();
        // Reset held with events present: every output must read 0.
        reset           = 1'b1;
        bus.m_valid     = 1'b1;
        bus.m_pc        = 32'h0000_3000;
        bus.m_bd        = 1'b1;
        bus.m_exc_valid = 1'b1;
        bus.m_exc_code  = 5'd12;
        bus.m_is_eret   = 1'b0;
        bus.int_req     = 1'b1;
        bus.cp0_epc     = 32'h0000_1234;
        model_reset();
        #3;
        check_all("reset_init", z);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        idle("post_reset");

        // Overflow exception, not in delay slot; 2 drain cycles follow.
        step("ov_entry", 1'b1, 32'h0000_3010, 1'b0, 1'b1, 5'd12, 1'b0, 1'b0, 32'h0);
        idle("ov_drain0");
        idle("ov_drain1");
        idle("ov_idle");

        // Interrupt during bubbles is not taken until a valid M instruction.
        for (int i = 0; i < 3; i++)
            step("int_bubble", 1'b0, 32'h0000_3018, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 32'h0);
        step("int_entry", 1'b1, 32'h0000_3020, 1'b1, 1'b0, 5'd0, 1'b0, 1'b1, 32'h0);
        idle("int_drain0");
        idle("int_drain1");

        // ERET return, then ERET with a coincident interrupt.
        step("eret", 1'b1, 32'h0000_3030, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 32'h0000_3014);
        idle("eret_drain0");
        idle("eret_drain1");
        step("eret_int", 1'b1, 32'h0000_3040, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 32'h0000_3014);
        idle("eret_int_drain0");
        idle("eret_int_drain1");

        // Interrupt beats a coincident synchronous exception.
        step("int_vs_exc", 1'b1, 32'h0000_3050, 1'b1, 1'b1, 5'd10, 1'b0, 1'b1, 32'h0);
        idle("ive_drain0");
        idle("ive_drain1");

        // Events arriving in DRAIN are ignored.
        step("adel_entry", 1'b1, 32'h0000_3060, 1'b0, 1'b1, 5'd4, 1'b0, 1'b0, 32'h0);
        step("drain_exc", 1'b1, 32'h0000_3064, 1'b0, 1'b1, 5'd10, 1'b0, 1'b0, 32'h0);
        step("drain_eret", 1'b1, 32'h0000_3068, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 32'h0000_5000);
        step("ades_entry", 1'b1, 32'h0000_3070, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0, 32'h0);

        // Reset mid-DRAIN with a valid interrupt present: busy and strobes drop at once.
        bus.m_valid = 1'b1;
        bus.int_req = 1'b1;
        bus.m_pc    = 32'h0000_3074;
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        check_all("reset_drain", z);
        @(negedge clk);
        reset = 1'b0;
        idle("after_reset");

        // Saturation: preload the debug counter just below its ceiling.
        force dut.taken_cnt_q = 16'hFFFD;
        #1;
        release dut.taken_cnt_q;
        mdl_taken = 16'hFFFD;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            step("sat_entry", 1'b1, 32'h0000_3100 + 32'(i * 4), 1'b0, 1'b1, 5'd12, 1'b0, 1'b0, 32'h0);
            idle("sat_drain0");
            idle("sat_drain1");
        end
        idle("sat_final");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
